// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants for the branch resolve sequencer: comparator opcodes and FSM states.
package branch_resolve_ctrl_pkg;

   localparam int CMP_EQUAL   = 1;
   localparam int CMP_UNEQUAL = 2;

   typedef enum logic [1:0] {
      BRC_IDLE  = 2'd0,
      BRC_WAIT  = 2'd1,
      BRC_REDIR = 2'd2
   } brc_state_t;

endpackage

// File: rtl/br_stat_counter.sv
// Free-running statistics counter; increments on inc, wraps modulo 2^CNT_W.
module br_stat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] value
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         value <= '0;
      else if (inc)
         value <= value + CNT_W'(1);
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// D-stage branch sequencer: waits for forwarded operands, drives the comparator op,
// resolves the branch and holds a PC redirect toward IF until it is accepted.
module branch_resolve_ctrl
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int OP_W  = 8,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             br_valid,
   input  logic [OP_W-1:0]  br_type,
   input  logic [31:0]      br_target,
   input  logic             rs_ready,
   input  logic             rt_ready,
   input  logic             flush,
   input  logic             cmp_out,
   output logic [OP_W-1:0]  cmp_op,
   output logic             stall_d,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   input  logic             redirect_ready,
   output logic             illegal_op,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   localparam logic [OP_W-1:0] OP_EQ = OP_W'(CMP_EQUAL);
   localparam logic [OP_W-1:0] OP_NE = OP_W'(CMP_UNEQUAL);

   brc_state_t      state, state_nxt;
   logic [OP_W-1:0] lat_type;
   logic [31:0]     lat_target;
   logic            rdy;
   logic [OP_W-1:0] cur_type;
   logic [31:0]     cur_target;
   logic            cur_legal;
   logic            resolve;
   logic            taken;

   // In WAIT the branch has already left the decoder inputs, so use the latched copy.
   always_comb begin
      rdy        = rs_ready & rt_ready;
      cur_type   = (state == BRC_WAIT) ? lat_type : br_type;
      cur_target = (state == BRC_WAIT) ? lat_target : br_target;
      cur_legal  = (cur_type == OP_EQ) || (cur_type == OP_NE);
      resolve    = !flush && rdy &&
                   (((state == BRC_IDLE) && br_valid) || (state == BRC_WAIT));
      taken      = resolve && cmp_out && cur_legal;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= BRC_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush)
         state_nxt = BRC_IDLE;
      else begin
         case (state)
            BRC_IDLE: begin
               if (br_valid && !rdy)
                  state_nxt = BRC_WAIT;
               else if (taken)
                  state_nxt = BRC_REDIR;
            end
            BRC_WAIT: begin
               if (rdy)
                  state_nxt = taken ? BRC_REDIR : BRC_IDLE;
            end
            BRC_REDIR: begin
               if (redirect_ready)
                  state_nxt = BRC_IDLE;
            end
            default: state_nxt = BRC_IDLE;
         endcase
      end
   end

   // Outputs are forced to reset values while reset is held, independent of inputs.
   always_comb begin
      stall_d        = 1'b0;
      cmp_op         = OP_EQ;
      redirect_valid = 1'b0;
      if (reset) begin
         redirect_valid = (state == BRC_REDIR);
         if (!flush) begin
            case (state)
               BRC_IDLE:  stall_d = br_valid && !rdy;
               BRC_WAIT:  stall_d = !rdy;
               BRC_REDIR: stall_d = br_valid;
               default:   stall_d = 1'b0;
            endcase
         end
         if ((((state == BRC_IDLE) && br_valid) || (state == BRC_WAIT)) && cur_legal)
            cmp_op = cur_type;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_type    <= OP_EQ;
         lat_target  <= '0;
         redirect_pc <= '0;
         illegal_op  <= 1'b0;
      end else begin
         if ((state == BRC_IDLE) && br_valid && !rdy && !flush) begin
            lat_type   <= br_type;
            lat_target <= br_target;
         end
         if (taken)
            redirect_pc <= cur_target;
         illegal_op <= resolve && !cur_legal;
      end
   end

   br_stat_counter #(.CNT_W(CNT_W)) u_br_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (resolve),
      .value (br_cnt)
   );

   br_stat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (taken),
      .value (taken_cnt)
   );

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch_resolve_ctrl;
   import branch_resolve_ctrl_pkg::*;

   localparam logic [7:0] EQ = 8'(CMP_EQUAL);
   localparam logic [7:0] NE = 8'(CMP_UNEQUAL);

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        br_valid = 1'b0;
   logic [7:0]  br_type = 8'h00;
   logic [31:0] br_target = 32'h0;
   logic        rs_ready = 1'b0;
   logic        rt_ready = 1'b0;
   logic        flush = 1'b0;
   logic        cmp_out = 1'b0;
   logic        redirect_ready = 1'b0;

   logic [7:0]  cmp_op, cmp_op4;
   logic        stall_d, stall_d4;
   logic        redirect_valid, redirect_valid4;
   logic [31:0] redirect_pc, redirect_pc4;
   logic        illegal_op, illegal_op4;
   logic [31:0] br_cnt, taken_cnt;
   logic [3:0]  br_cnt4, taken_cnt4;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.OP_W(8), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type), .br_target(br_target),
      .rs_ready(rs_ready), .rt_ready(rt_ready), .flush(flush), .cmp_out(cmp_out),
      .cmp_op(cmp_op), .stall_d(stall_d), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .illegal_op(illegal_op),
      .br_cnt(br_cnt), .taken_cnt(taken_cnt)
   );

   branch_resolve_ctrl #(.OP_W(8), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type), .br_target(br_target),
      .rs_ready(rs_ready), .rt_ready(rt_ready), .flush(flush), .cmp_out(cmp_out),
      .cmp_op(cmp_op4), .stall_d(stall_d4), .redirect_valid(redirect_valid4),
      .redirect_pc(redirect_pc4), .redirect_ready(redirect_ready), .illegal_op(illegal_op4),
      .br_cnt(br_cnt4), .taken_cnt(taken_cnt4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [7:0] t);
      return (t == EQ) || (t == NE);
   endfunction

   // Behavioural model: a pending (operand-stalled) branch, an outstanding redirect, counters.
   bit          m_pend, m_redir, m_ill;
   logic [7:0]  m_type;
   logic [31:0] m_tgt, m_pc, m_br, m_tk;
   bit          m_go;
   logic [7:0]  m_t;
   logic [31:0] m_g;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pend = 0; m_redir = 0; m_ill = 0;
         m_type = EQ; m_tgt = 0; m_pc = 0; m_br = 0; m_tk = 0;
      end else if (flush) begin
         m_pend = 0; m_redir = 0; m_ill = 0;
      end else if (m_redir) begin
         m_ill = 0;
         if (redirect_ready) m_redir = 0;
      end else begin
         m_go = m_pend ? (rs_ready && rt_ready) : (br_valid && rs_ready && rt_ready);
         m_t  = m_pend ? m_type : br_type;
         m_g  = m_pend ? m_tgt : br_target;
         m_ill = 0;
         if (m_go) begin
            m_br = m_br + 1;
            m_pend = 0;
            if (!legal(m_t)) m_ill = 1;
            else if (cmp_out) begin
               m_tk = m_tk + 1;
               m_redir = 1;
               m_pc = m_g;
            end
         end else if (!m_pend && br_valid) begin
            m_pend = 1; m_type = br_type; m_tgt = br_target;
         end
      end
   end

   logic       e_stall;
   logic [7:0] e_op;

   always @(negedge clk) begin
      if (run_cmp) begin
         e_stall = 0;
         e_op = EQ;
         if (reset) begin
            if (!flush)
               e_stall = m_redir ? br_valid : (m_pend ? !(rs_ready && rt_ready)
                                                      : (br_valid && !(rs_ready && rt_ready)));
            if (!m_redir && m_pend && legal(m_type)) e_op = m_type;
            else if (!m_redir && !m_pend && br_valid && legal(br_type)) e_op = br_type;
         end
         chk("m_stall_d", {31'b0, stall_d}, {31'b0, e_stall});
         chk("m_cmp_op", {24'b0, cmp_op}, {24'b0, e_op});
         chk("m_redirect_valid", {31'b0, redirect_valid}, {31'b0, m_redir});
         chk("m_redirect_pc", redirect_pc, m_pc);
         chk("m_illegal_op", {31'b0, illegal_op}, {31'b0, m_ill});
         chk("m_br_cnt", br_cnt, m_br);
         chk("m_taken_cnt", taken_cnt, m_tk);
         chk("m_br_cnt_w4", {28'b0, br_cnt4}, {28'b0, m_br[3:0]});
         chk("m_taken_cnt_w4", {28'b0, taken_cnt4}, {28'b0, m_tk[3:0]});
      end
   end

   task automatic step(input bit bv, input logic [7:0] ty, input logic [31:0] tg,
                       input bit rs, input bit rt, input bit fl, input bit co, input bit rr);
      @(posedge clk);
      #1;
      br_valid = bv; br_type = ty; br_target = tg; rs_ready = rs; rt_ready = rt;
      flush = fl; cmp_out = co; redirect_ready = rr;
      @(negedge clk);
   endtask

   int r;

   initial begin
      #12;
      chk("rst_stall_d", {31'b0, stall_d}, 32'h0);
      chk("rst_cmp_op", {24'b0, cmp_op}, {24'b0, EQ});
      chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      chk("rst_br_cnt", br_cnt, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      run_cmp = 1'b1;

      // Ready taken branch, then redirect held under backpressure for three cycles.
      step(1, EQ, 32'h0000_3010, 1, 1, 0, 1, 0);
      chk("t1_stall_d", {31'b0, stall_d}, 32'h0);
      step(0, EQ, 32'h0, 1, 1, 0, 0, 0);
      chk("t1_redirect_valid", {31'b0, redirect_valid}, 32'h1);
      chk("t1_redirect_pc", redirect_pc, 32'h0000_3010);
      chk("t1_br_cnt", br_cnt, 32'd1);
      chk("t1_taken_cnt", taken_cnt, 32'd1);
      step(0, EQ, 32'h0, 1, 1, 0, 0, 0);
      step(0, EQ, 32'h0, 1, 1, 0, 0, 0);
      chk("bp_held_valid", {31'b0, redirect_valid}, 32'h1);
      chk("bp_held_pc", redirect_pc, 32'h0000_3010);
      step(0, EQ, 32'h0, 1, 1, 0, 0, 1);
      chk("bp_ready_cycle_valid", {31'b0, redirect_valid}, 32'h1);
      step(0, EQ, 32'h0, 1, 1, 0, 0, 0);
      chk("bp_dropped_valid", {31'b0, redirect_valid}, 32'h0);

      // Operand hazard for two cycles, not-taken unequal compare.
      step(1, NE, 32'h0000_4000, 0, 1, 0, 0, 0);
      chk("hz_stall_1", {31'b0, stall_d}, 32'h1);
      chk("hz_cmp_op_1", {24'b0, cmp_op}, {24'b0, NE});
      step(1, NE, 32'h0000_4000, 0, 1, 0, 0, 0);
      chk("hz_stall_2", {31'b0, stall_d}, 32'h1);
      step(1, NE, 32'h0000_4000, 1, 1, 0, 0, 0);
      chk("hz_stall_release", {31'b0, stall_d}, 32'h0);
      chk("hz_cmp_op_3", {24'b0, cmp_op}, {24'b0, NE});
      step(0, EQ, 32'h0, 1, 1, 0, 0, 0);
      chk("hz_no_redirect", {31'b0, redirect_valid}, 32'h0);
      chk("hz_br_cnt", br_cnt, 32'd2);
      chk("hz_taken_cnt", taken_cnt, 32'd1);

      // Flush while waiting on operands discards the pending branch.
      step(1, EQ, 32'h0000_5000, 0, 0, 0, 1, 0);
      chk("fw_stall", {31'b0, stall_d}, 32'h1);
      step(1, EQ, 32'h0000_5000, 0, 0, 1, 1, 0);
      chk("fw_flush_stall", {31'b0, stall_d}, 32'h0);
      step(0, EQ, 32'h0, 1, 1, 0, 1, 0);
      step(0, EQ, 32'h0, 1, 1, 0, 1, 0);
      chk("fw_br_cnt", br_cnt, 32'd2);
      chk("fw_redirect_valid", {31'b0, redirect_valid}, 32'h0);

      // Flush while a redirect is outstanding.
      step(1, EQ, 32'h0000_6000, 1, 1, 0, 1, 0);
      step(0, EQ, 32'h0, 1, 1, 0, 0, 0);
      chk("fr_redirect_pc", redirect_pc, 32'h0000_6000);
      step(0, EQ, 32'h0, 1, 1, 1, 0, 0);
      chk("fr_flush_stall", {31'b0, stall_d}, 32'h0);
      step(0, EQ, 32'h0, 1, 1, 0, 0, 0);
      chk("fr_redirect_valid", {31'b0, redirect_valid}, 32'h0);
      chk("fr_br_cnt", br_cnt, 32'd3);
      chk("fr_taken_cnt", taken_cnt, 32'd2);

      // Illegal opcode: not taken, one-cycle flag, still counted.
      step(1, 8'hFF, 32'h0000_7000, 1, 1, 0, 1, 0);
      chk("il_cmp_op", {24'b0, cmp_op}, {24'b0, EQ});
      step(0, EQ, 32'h0, 1, 1, 0, 0, 0);
      chk("il_pulse", {31'b0, illegal_op}, 32'h1);
      chk("il_no_redirect", {31'b0, redirect_valid}, 32'h0);
      chk("il_br_cnt", br_cnt, 32'd4);
      step(0, EQ, 32'h0, 1, 1, 0, 0, 0);
      chk("il_pulse_end", {31'b0, illegal_op}, 32'h0);

      // Randomized traffic; the narrow-counter instance wraps many times here.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         r = $urandom_range(0, 9);
         br_valid       = ($urandom_range(0, 1) == 1);
         br_type        = (r < 4) ? EQ : (r < 8) ? NE : 8'($urandom);
         br_target      = $urandom;
         rs_ready       = ($urandom_range(0, 9) < 7);
         rt_ready       = ($urandom_range(0, 9) < 7);
         flush          = ($urandom_range(0, 31) == 0);
         cmp_out        = ($urandom_range(0, 1) == 1);
         redirect_ready = ($urandom_range(0, 1) == 1);
      end
      step(0, EQ, 32'h0, 1, 1, 1, 0, 0);
      chk("rnd_wrapped", {31'b0, (m_br > 32'd16)}, 32'h1);

      // Asynchronous reset while a redirect is pending.
      step(1, EQ, 32'h0000_8000, 1, 1, 0, 1, 0);
      step(0, EQ, 32'h0, 1, 1, 0, 0, 0);
      chk("ar_pre_valid", {31'b0, redirect_valid}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_redirect_valid", {31'b0, redirect_valid}, 32'h0);
      chk("ar_redirect_pc", redirect_pc, 32'h0);
      chk("ar_stall_d", {31'b0, stall_d}, 32'h0);
      chk("ar_cmp_op", {24'b0, cmp_op}, {24'b0, EQ});
      chk("ar_br_cnt", br_cnt, 32'h0);
      chk("ar_taken_cnt", taken_cnt, 32'h0);
      chk("ar_br_cnt_w4", {28'b0, br_cnt4}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      step(0, EQ, 32'h0, 1, 1, 0, 0, 0);
      step(0, EQ, 32'h0, 1, 1, 0, 0, 0);
      run_cmp = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- D-stage sequencer for the branch comparator (CMP). Accepts a decoded branch, stalls D until both forwarded operands are valid, then drives CMPOp and samples CMPOut.
- Holds a PC redirect toward IF with a valid/ready handshake. Keeps branch and taken statistics.
- Sits between the decoder/hazard unit, the CMP instance (outside this block) and the IF-stage NPC mux.

Parameters:
OP_W, 8, width of comparator opcode; matches the CMPOp port of CMP
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
br_valid  in  1  D-stage instruction is a conditional branch
br_type  in  OP_W  comparator op for this branch (`cmpEqual / `cmpUnequal)
br_target  in  32  branch target computed in D
rs_ready  in  1  forwarded rs value valid this cycle
rt_ready  in  1  forwarded rt value valid this cycle
flush  in  1  exception/eret flush from CP0
cmp_out  in  1  CMPOut from comparator
cmp_op  out  OP_W  drives CMPOp of comparator
stall_d  out  1  freeze PC/F/D registers
redirect_valid  out  1  redirect request to IF
redirect_pc  out  32  redirect target
redirect_ready  in  1  IF accepts redirect this cycle
illegal_op  out  1  one-cycle pulse: br_type not a known compare op
br_cnt  out  CNT_W  resolved branches
taken_cnt  out  CNT_W  taken branches

Behaviour:
- Reset (async, reset=0): state IDLE; cmp_op=`cmpEqual; stall_d=0; redirect_valid=0; redirect_pc=0; illegal_op=0; both counters 0. Outputs must be defined during reset.
- cmp_op is never left undriven or illegal. CMP holds its previous value on an unknown op.
  - IDLE: `cmpEqual unless br_valid, in which case br_type.
  - WAIT: latched type.
  - Unknown op: forced to `cmpEqual.
- rdy = rs_ready & rt_ready.
- States: IDLE, WAIT, REDIRECT.
- IDLE:
  - No br_valid: stay.
  - br_valid & !rdy: latch br_type and br_target; stall_d=1 (combinational); go WAIT.
  - br_valid & rdy: resolve this cycle with stall_d=0, then:
    - taken = cmp_out and op legal.
    - br_cnt++.
    - If taken: taken_cnt++, register redirect_pc=br_target, go REDIRECT. Otherwise stay IDLE.
- WAIT:
  - stall_d=1 while !rdy.
  - On rdy: stall_d=0, resolve exactly as in IDLE using the latched type/target.
- REDIRECT:
  - redirect_valid=1; redirect_pc stable until accepted.
  - If br_valid asserts in REDIRECT, stall_d=1 and the branch is not resolved (no back-to-back resolution). The delay slot proceeds as normal.
  - redirect_ready=1: redirect_valid drops next cycle, go IDLE.
- Latency: resolve cycle N, redirect_valid high from N+1; minimum 1 cycle in REDIRECT.
- Illegal br_type at resolve: illegal_op pulses 1 cycle (registered, N+1); treated as not taken; br_cnt still increments.
- flush (any state) has priority over everything:
  - Next state IDLE; redirect_valid=0 next cycle; pending latch discarded.
  - No counter increment in the flush cycle; stall_d=0 in the flush cycle.
- Counters wrap modulo 2^CNT_W with no saturation.
- redirect_ready while redirect_valid=0 is ignored.

Decomposition:
- constants.v: `cmpEqual, `cmpUnequal (existing) plus state encodings `BRC_IDLE, `BRC_WAIT, `BRC_REDIR.
- One sub-module, br_stat_counter (CNT_W, async active-low reset, inc, value), instantiated twice.
- CMP stays outside; this block only drives its op and reads its result.

Test Plan:
- Ready equal branch: br_valid=1, br_type=`cmpEqual, rdy=1, cmp_out=1, br_target=0x0000_3010 → stall_d=0; next cycle redirect_valid=1, redirect_pc=0x0000_3010; br_cnt=1, taken_cnt=1.
- Hazard stall: br_valid=1, rs_ready=0 for 2 cycles then 1, `cmpUnequal, cmp_out=0 → stall_d=1 for exactly 2 cycles; cmp_op=`cmpUnequal throughout; no redirect; br_cnt=1, taken_cnt=0.
- Redirect backpressure: taken branch, redirect_ready=0 for 3 cycles → redirect_valid and redirect_pc held 3 cycles, drop the cycle after ready=1.
- Flush: flush=1 in WAIT, and separately in REDIRECT → IDLE next cycle, redirect_valid=0, counters unchanged, stall_d=0.
- Illegal op: br_type=8'hFF, rdy=1, cmp_out=1 → no redirect, illegal_op one-cycle pulse, cmp_op=`cmpEqual, br_cnt+1.
- Async reset mid-REDIRECT: reset=0 asynchronously → all outputs immediately at reset values; counter wrap checked by preloading CNT_W=4 config (15 → 0).
